// File: rtl/risc8_outport_if.sv
// risc8_outport bus bundle: CPU data-memory side plus the output stream.
// slave = the port itself, master = CPU/consumer side.
interface risc8_outport_if;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       rd_hit;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    input  out_ready,
    output rd_hit,
    output rd_data,
    output out_data,
    output out_valid,
    output overflow
  );

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    output out_ready,
    input  rd_hit,
    input  rd_data,
    input  out_data,
    input  out_valid,
    input  overflow
  );
endinterface

// File: rtl/risc8_outport.sv
// risc8_outport: memory-mapped TX FIFO with valid/ready drain and status reg.
// Ports: clk, rst_n (async low), bus (slave: CPU store/status + out stream).
module risc8_outport #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] TX_ADDR   = 8'hFF,
  parameter logic [7:0] STAT_ADDR = 8'hFE
) (
  input logic            clk,
  input logic            rst_n,
  risc8_outport_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic push;
  logic pop;
  logic stat_wr;
  logic flush;
  logic ovf_clr;
  logic full;
  logic empty;
  logic accept;
  logic drop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = bus.mem_wr_en & (bus.mem_addr == TX_ADDR);
  assign pop     = ~empty & bus.out_ready;
  assign stat_wr = bus.mem_wr_en & (bus.mem_addr == STAT_ADDR);
  assign flush   = stat_wr & bus.mem_wr_data[0];
  assign ovf_clr = stat_wr & bus.mem_wr_data[7];
  // A same-cycle pop frees the slot, so a full FIFO still takes the push.
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= bus.mem_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop beats a same-cycle clear so a lost byte is never hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (drop)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? 8'h00 : mem[rd_ptr];
  assign bus.overflow  = ovf;
  assign bus.rd_hit    = (bus.mem_addr == STAT_ADDR);
  assign bus.rd_data   = bus.rd_hit
                       ? {ovf, full, empty, 1'b0, 4'(count)}
                       : 8'h00;
endmodule

// File: tb/tb_risc8_outport.sv
// Bench for risc8_outport: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a random stream.
module tb_risc8_outport;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  risc8_outport_if bus();

  risc8_outport dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned mq[$];
  bit           movf = 1'b0;
  byte unsigned rx[$];
  byte unsigned tx[$];

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_stat();
    int n;
    n = mq.size();
    return {movf, 1'(n == 8), 1'(n == 0), 1'b0, 4'(n)};
  endfunction

  function automatic logic [7:0] m_head();
    if (mq.size() == 0)
      return 8'h00;
    return mq[0];
  endfunction

  // Reference model: FIFO as a queue, updated from the rules on each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      bit push, pop, stat, drop;
      push = bus.mem_wr_en && bus.mem_addr == 8'hFF;
      stat = bus.mem_wr_en && bus.mem_addr == 8'hFE;
      pop  = mq.size() > 0 && bus.out_ready;
      drop = push && mq.size() == 8 && !pop;
      if (stat && bus.mem_wr_data[0]) begin
        mq.delete();
      end else begin
        if (pop)
          void'(mq.pop_front());
        if (push && !drop)
          mq.push_back(bus.mem_wr_data);
      end
      if (drop)
        movf = 1'b1;
      else if (stat && bus.mem_wr_data[7])
        movf = 1'b0;
    end
  end

  // Per-cycle compare away from the active edge, plus stream capture.
  always @(negedge clk) begin
    logic [7:0] exp_rd;
    exp_rd = (bus.mem_addr == 8'hFE) ? m_stat() : 8'h00;
    chk("out_valid", 8'(bus.out_valid), 8'(mq.size() != 0));
    chk("out_data", bus.out_data, m_head());
    chk("overflow", 8'(bus.overflow), 8'(movf));
    chk("rd_hit", 8'(bus.rd_hit), 8'(bus.mem_addr == 8'hFE));
    chk("rd_data", bus.rd_data, exp_rd);
    if (bus.out_valid && bus.out_ready)
      rx.push_back(bus.out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [7:0] a, logic [7:0] d);
    bus.mem_addr    = a;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_data = d;
    step();
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = 8'h10;
  endtask

  task automatic stat_is(string nm, logic [7:0] exp);
    bus.mem_addr = 8'hFE;
    #1;
    chk(nm, bus.rd_data, exp);
    bus.mem_addr = 8'h10;
  endtask

  initial begin
    logic [7:0] last;
    int         sent;

    // 1: reset with random inputs
    bus.mem_addr    = 8'($urandom);
    bus.mem_wr_en   = 1'($urandom);
    bus.mem_wr_data = 8'($urandom);
    bus.out_ready   = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 8'(bus.out_valid), 8'h00);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_ovf", 8'(bus.overflow), 8'h00);
    bus.mem_wr_en = 1'b0;
    bus.out_ready = 1'b0;
    stat_is("rst_stat", 8'h20);
    chk("rst_hit", 8'(bus.mem_addr == 8'hFE), 8'(1'b0));
    step();
    rst_n = 1'b1;
    step();

    // 2: single byte, held, then one pop
    store(8'hFF, 8'h41);
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid", 8'(bus.out_valid), 8'h01);
      chk("t2_data", bus.out_data, 8'h41);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t2_empty", 8'(bus.out_valid), 8'h00);

    // 3: fill, overflow, drain in order
    for (int i = 1; i <= 8; i++)
      store(8'hFF, 8'(i));
    stat_is("t3_full", 8'h48);
    store(8'hFF, 8'h09);
    stat_is("t3_ovf", 8'hC8);
    chk("t3_ovf_bit", 8'(bus.overflow), 8'h01);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", bus.out_data, 8'(i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("t3_empty", 8'(bus.out_valid), 8'h00);

    // 4: full, push and pop in the same cycle
    store(8'hFE, 8'h80);
    chk("t4_clr", 8'(bus.overflow), 8'h00);
    for (int i = 0; i < 8; i++)
      store(8'hFF, 8'(8'h11 + i));
    bus.mem_addr    = 8'hFF;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_data = 8'h0A;
    bus.out_ready   = 1'b1;
    step();
    bus.mem_wr_en   = 1'b0;
    bus.out_ready   = 1'b0;
    stat_is("t4_stat", 8'h48);
    chk("t4_ovf", 8'(bus.overflow), 8'h00);
    chk("t4_head", bus.out_data, 8'h12);
    bus.out_ready = 1'b1;
    last = 8'h00;
    repeat (8) begin
      last = bus.out_data;
      step();
    end
    bus.out_ready = 1'b0;
    chk("t4_last", last, 8'h0A);

    // 5: overflow set, 3 queued, clear + flush
    for (int i = 0; i < 9; i++)
      store(8'hFF, 8'(8'h21 + i));
    bus.out_ready = 1'b1;
    repeat (5) step();
    bus.out_ready = 1'b0;
    stat_is("t5_pre", 8'h83);
    chk("t5_head", bus.out_data, 8'h26);
    store(8'hFE, 8'h81);
    chk("t5_ovf", 8'(bus.overflow), 8'h00);
    chk("t5_valid", 8'(bus.out_valid), 8'h00);
    stat_is("t5_stat", 8'h20);

    // 6: random stream with random backpressure
    rx.delete();
    tx.delete();
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      bus.out_ready = 1'($urandom);
      if (mq.size() < 8 && $urandom_range(0, 2) != 0) begin
        bus.mem_addr    = 8'hFF;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = 8'($urandom);
        tx.push_back(bus.mem_wr_data);
        sent++;
      end else begin
        bus.mem_wr_en   = 1'b0;
        bus.mem_addr    = 8'($urandom_range(0, 253));
        bus.mem_wr_data = 8'($urandom);
      end
      step();
    end
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = 8'h10;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && mq.size() > 0; c++)
      step();
    bus.out_ready = 1'b0;
    chk("t6_sent", 8'(sent), 8'd20);
    chk("t6_len", 8'(rx.size()), 8'(tx.size()));
    for (int i = 0; i < tx.size() && i < rx.size(); i++)
      chk("t6_order", rx[i], tx[i]);

    // mid-stream async reset
    store(8'hFF, 8'h5A);
    store(8'hFF, 8'hA5);
    chk("t6_pre_rst", 8'(bus.out_valid), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 8'(bus.out_valid), 8'h00);
    chk("t6_rst_data", bus.out_data, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
